// File: rtl/epp_regbank_pkg.sv
// Shared constants for the EPP register bank: address map, STATUS bit
// positions and the controller state encoding.
package epp_regbank_pkg;

  localparam logic [7:0] CFG_BASE  = 8'h00;
  localparam logic [7:0] STATUS    = 8'h08;
  localparam logic [7:0] LEVEL     = 8'h09;
  localparam logic [7:0] FIFO_PORT = 8'h0A;
  localparam logic [7:0] EXT_BASE  = 8'h80;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_ERR   = 3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_PUSH = 2'd1,
    S_EXT_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with level output. A push while full is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/epp_regbank.sv
// EPP-side register bank: config bytes, STATUS, command FIFO push port and
// a bridged external window with timeout.
module epp_regbank
  import epp_regbank_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ip_addr,
  input  logic [7:0]  ip_do,
  input  logic        ip_wr,
  input  logic        ip_rd,
  output logic [7:0]  ip_di,
  output logic        ip_do_rdy,
  output logic [63:0] cfg,
  output logic [7:0]  cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        ext_req,
  output logic        ext_we,
  output logic [6:0]  ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        busy,
  output state_t      dbg_state
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Front-end handshake: a one-cycle ip_wr/ip_rd pulse is accepted only while
  // ip_do_rdy is high; ip_do_rdy returns high once the access has completed
  // and ip_di holds the read result.
  state_t          state, state_nxt;
  logic [7:0][7:0] cfg_q;
  logic            err;
  logic [7:0]      pend_byte;
  logic [TW-1:0]   tcnt;
  logic            acc, ext_hit, push_req, pop, room, expired;
  logic            fifo_push, fifo_full, fifo_empty;
  logic [7:0]      fifo_din, rd_data, status_byte;
  logic [LW-1:0]   fifo_level;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (cmd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cmd_valid = ~fifo_empty;
  assign cfg       = cfg_q;
  assign busy      = (state != S_IDLE);
  assign ip_do_rdy = ~busy;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ext_hit)                state_nxt = S_EXT_WAIT;
        else if (push_req && !room) state_nxt = S_WAIT_PUSH;
      end
      S_WAIT_PUSH: if (room)               state_nxt = S_IDLE;
      S_EXT_WAIT:  if (ext_ack || expired) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Write wins when ip_wr and ip_rd arrive together.
  always_comb begin
    acc       = ip_wr | ip_rd;
    ext_hit   = acc & (ip_addr >= EXT_BASE);
    push_req  = ip_wr & (ip_addr == FIFO_PORT);
    pop       = cmd_valid & cmd_ready;
    room      = ~fifo_full | pop;
    expired   = (tcnt == TW'(TIMEOUT - 1));
    fifo_push = 1'b0;
    fifo_din  = ip_do;
    case (state)
      S_IDLE:      fifo_push = push_req & room;
      S_WAIT_PUSH: begin
        fifo_push = room;
        fifo_din  = pend_byte;
      end
      default:     fifo_push = 1'b0;
    endcase
  end

  always_comb begin
    status_byte           = 8'h00;
    status_byte[ST_EMPTY] = fifo_empty;
    status_byte[ST_FULL]  = fifo_full;
    status_byte[ST_OVF]   = 1'b0;
    status_byte[ST_ERR]   = err;
    rd_data = 8'h00;
    if (ip_addr[7:3] == CFG_BASE[7:3]) rd_data = cfg_q[ip_addr[2:0]];
    else if (ip_addr == STATUS)        rd_data = status_byte;
    else if (ip_addr == LEVEL)         rd_data = 8'(fifo_level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q     <= '0;
      ip_di     <= 8'h00;
      err       <= 1'b0;
      pend_byte <= 8'h00;
      tcnt      <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 7'h00;
      ext_wdata <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (ext_hit) begin
            ext_req   <= 1'b1;
            ext_we    <= ip_wr;
            ext_addr  <= ip_addr[6:0];
            ext_wdata <= ip_do;
            tcnt      <= '0;
          end else if (ip_wr) begin
            if (ip_addr[7:3] == CFG_BASE[7:3])       cfg_q[ip_addr[2:0]] <= ip_do;
            else if (ip_addr == STATUS && ip_do[ST_ERR]) err <= 1'b0;
            else if (ip_addr == FIFO_PORT && !room)  pend_byte <= ip_do;
          end else if (ip_rd) begin
            ip_di <= rd_data;
          end
        end
        S_EXT_WAIT: begin
          // An ack arriving in the expiry cycle takes precedence.
          if (ext_ack) begin
            ext_req <= 1'b0;
            if (!ext_we) ip_di <= ext_rdata;
          end else if (expired) begin
            ext_req <= 1'b0;
            err     <= 1'b1;
            if (!ext_we) ip_di <= 8'hFF;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_epp_regbank.sv
// Randomized self-checking bench for epp_regbank against a register/queue model.
module tb_epp_regbank;
  localparam int DEPTH = 16;
  localparam int TMO   = 255;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  ip_addr = 8'h00, ip_do = 8'h00, ip_di, cmd_data, ext_wdata, ext_rdata = 8'h00;
  logic        ip_wr = 1'b0, ip_rd = 1'b0, ip_do_rdy, cmd_valid, cmd_ready = 1'b0;
  logic        ext_req, ext_we, ext_ack = 1'b0, busy;
  logic [6:0]  ext_addr;
  logic [63:0] cfg;
  logic [1:0]  dbg_state;

  epp_regbank #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ip_addr(ip_addr), .ip_do(ip_do), .ip_wr(ip_wr), .ip_rd(ip_rd),
    .ip_di(ip_di), .ip_do_rdy(ip_do_rdy), .cfg(cfg), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [7:0] m_cfg [8];
  logic       m_err = 1'b0;
  logic [7:0] m_di = 8'h00;
  logic [7:0] exp_q [$];
  int         n_checks = 0, n_fail = 0, n_pops = 0, rdy_drops = 0;
  logic       watch_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_cfg_flat();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  function automatic logic [7:0] m_status();
    return {4'b0, m_err, 1'b0, exp_q.size() == DEPTH, exp_q.size() == 0};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_cfg[i] = 8'h00;
    m_err = 1'b0;
    m_di  = 8'h00;
    exp_q.delete();
  endfunction

  // Pops are checked in order against everything the bench has pushed.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      n_pops++;
      if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
      else check("pop_data", cmd_data, exp_q.pop_front());
    end
    if (watch_rdy && !ip_do_rdy) rdy_drops++;
  end

  task automatic pulse(input logic wr, input logic rd, input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #2;
    ip_wr = wr; ip_rd = rd; ip_addr = addr; ip_do = data;
    @(posedge clk); #2;
    ip_wr = 1'b0; ip_rd = 1'b0;
  endtask

  task automatic wr_local(input logic [7:0] addr, input logic [7:0] data);
    pulse(1'b1, 1'b0, addr, data);
    if (addr < 8'h08) m_cfg[addr[2:0]] = data;
    else if (addr == 8'h08 && data[3]) m_err = 1'b0;
    else if (addr == 8'h0A) exp_q.push_back(data);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    pulse(1'b0, 1'b1, addr, 8'($urandom));
    m_di = exp;
    check(tag, ip_di, exp);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && !ip_do_rdy; i++) begin
      @(posedge clk); #2;
    end
    check(tag, ip_do_rdy, 1);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    cmd_ready = 1'b0;
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_valid", cmd_valid, 0);
  endtask

  task automatic ext_access(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                            input int delay, input logic [7:0] rdata);
    pulse(wr, !wr, addr, data);
    check("ext_req_up", ext_req, 1);
    check("ext_cmd", {ext_we, ext_addr, busy, ip_do_rdy}, {wr, addr[6:0], 1'b1, 1'b0});
    if (wr) check("ext_wdata", ext_wdata, data);
    repeat (delay) begin @(posedge clk); #2; end
    check("ext_req_held", ext_req, 1);
    ext_ack = 1'b1; ext_rdata = rdata;
    @(posedge clk); #2;
    ext_ack = 1'b0; ext_rdata = 8'($urandom);
    if (!wr) m_di = rdata;
    check("ext_done", {ext_req, ip_do_rdy}, {1'b0, 1'b1});
    check("ext_di", ip_di, m_di);
  endtask

  task automatic ext_timeout(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    int n = 0;
    pulse(wr, !wr, addr, data);
    for (int i = 0; i < 2 * TMO; i++) begin
      @(negedge clk);
      if (!ext_req) break;
      n++;
    end
    check("tmo_cycles", n, TMO);
    m_err = 1'b1;
    if (!wr) m_di = 8'hFF;
    check("tmo_rdy", ip_do_rdy, 1);
    check("tmo_di", ip_di, m_di);
  endtask

  task automatic reset_outputs(input string tag);
    check(tag, {ip_do_rdy, busy, cmd_valid, ext_req, ext_we, ext_addr, ext_wdata, ip_di},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00});
    check({tag, "_cfg"}, cfg, 64'h0);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b1; ext_ack = 1'b0; cmd_ready = 1'b0;
    #1;
    reset_outputs(tag);
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset_outputs("reset");
    rst = 1'b0;

    // Config write/read without ready dropping
    watch_rdy = 1'b1;
    wr_local(8'h03, 8'h5A);
    rd_check("cfg3_read", 8'h03, 8'h5A);
    check("cfg3_byte", cfg[31:24], 8'h5A);
    watch_rdy = 1'b0;
    check("cfg_rdy_never_low", rdy_drops, 0);

    for (int i = 0; i < 24; i++) begin
      wr_local(8'($urandom_range(0, 7)), 8'($urandom));
      a = 8'($urandom_range(0, 7));
      rd_check("cfg_rand_read", a, m_cfg[a[2:0]]);
      check("cfg_rand_flat", cfg, m_cfg_flat());
    end

    // Unmapped and write-only addresses
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(11, 127));
      wr_local(a, 8'($urandom));
      rd_check("unmapped_read", a, 8'h00);
      check("unmapped_cfg", cfg, m_cfg_flat());
    end
    wr_local(8'h0A, 8'h77);
    rd_check("port_read", 8'h0A, 8'h00);
    drain();

    // Simultaneous write and read acts as a write only
    d = 8'($urandom);
    pulse(1'b1, 1'b1, 8'h05, d);
    m_cfg[5] = d;
    check("wr_rd_cfg", cfg, m_cfg_flat());
    check("wr_rd_di", ip_di, m_di);

    // Fill to full, then one more push stalls
    rd_check("status_empty", 8'h08, m_status());
    for (int i = 0; i < DEPTH; i++) begin
      wr_local(8'h0A, 8'(i));
      check("fill_rdy", ip_do_rdy, 1);
    end
    rd_check("level_full", 8'h09, 8'(exp_q.size()));
    rd_check("status_full", 8'h08, m_status());
    n_pops = 0;
    wr_local(8'h0A, 8'h10);
    check("stall_rdy_busy", {ip_do_rdy, busy}, {1'b0, 1'b1});
    repeat (5) @(posedge clk);
    #2;
    check("stall_hold", {ip_do_rdy, busy}, {1'b0, 1'b1});
    cmd_ready = 1'b1;
    wait_idle("stall_release", 10);
    drain();
    check("stall_pops", n_pops, DEPTH + 1);
    rd_check("level_zero", 8'h09, 8'h00);

    // Random push/pop traffic
    for (int i = 0; i < 48; i++) begin
      wr_local(8'h0A, 8'($urandom));
      if (!ip_do_rdy) begin
        cmd_ready = 1'b1;
        wait_idle("rand_push_idle", 10);
      end
      cmd_ready = ($urandom_range(0, 3) == 0);
      if (i % 8 == 7) begin
        cmd_ready = 1'b0;
        rd_check("rand_level", 8'h09, 8'(exp_q.size()));
        rd_check("rand_status", 8'h08, m_status());
      end
    end
    drain();

    // External window
    ext_access(1'b0, 8'h85, 8'h00, 3, 8'hC3);
    rd_check("ext_status", 8'h08, m_status());
    for (int i = 0; i < 10; i++)
      ext_access(1'($urandom), 8'h80 | 8'($urandom_range(0, 127)), 8'($urandom),
                 $urandom_range(0, 8), 8'($urandom));

    // Timeout on a write, then clear err
    wr_local(8'h0A, 8'hE1);
    ext_timeout(1'b1, 8'h90, 8'h42);
    rd_check("tmo_status_err", 8'h08, m_status());
    drain();
    wr_local(8'h08, 8'h08);
    rd_check("err_cleared", 8'h08, m_status());

    // Timeout on a read; clearing needs bit3
    ext_timeout(1'b0, 8'hA7, 8'h00);
    wr_local(8'h08, 8'hF7);
    rd_check("err_kept", 8'h08, m_status());
    wr_local(8'h08, 8'hFF);
    rd_check("err_cleared2", 8'h08, m_status());

    // Ack in the expiry cycle wins
    ext_access(1'b0, 8'hC4, 8'h00, TMO - 1, 8'h3C);
    rd_check("late_ack_status", 8'h08, m_status());

    // Reset during EXT_WAIT
    wr_local(8'h02, 8'h99);
    pulse(1'b0, 1'b1, 8'h81, 8'h00);
    repeat (5) @(posedge clk);
    mid_reset("rst_ext");
    rd_check("rst_ext_status", 8'h08, m_status());

    // Reset during WAIT_PUSH: pending byte is dropped
    for (int i = 0; i < DEPTH; i++) wr_local(8'h0A, 8'($urandom));
    wr_local(8'h0A, 8'hAB);
    check("wp_busy", busy, 1);
    mid_reset("rst_wp");
    repeat (4) @(posedge clk);
    #2;
    check("rst_wp_empty", cmd_valid, 0);
    rd_check("rst_wp_level", 8'h09, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
